// File: rtl/alu_seq.sv
// alu_seq -- instruction sequencer for a 4-bit accumulator ALU.
//
// Accepts 8-bit instructions ({opcode, immediate}) over a valid/ready
// handshake. Each instruction is expanded into a fixed control sequence on the
// ALU pins. Accumulator read-outs are returned over a second valid/ready channel.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   instr_valid/instr_ready   instruction handshake
//   instr[7:4]                opcode; instr[3:0] immediate
//   alu_tin, alu_pin          ALU second operand / accumulator load value
//   alu_cmode                 00 add, 01 and, 10 or, 11 xor
//   alu_inmode                1 = accumulator loads alu_pin
//   alu_outmode               0 = accumulator drives alu_bus
//   alu_uacc                  accumulator/flag write strobe
//   alu_bus, alu_flgs         accumulator read-back and {carry, parity, zero}
//   res_valid/res_ready       read-out handshake, with res_data/res_flgs
//   illegal                   one-cycle pulse after an undefined opcode is accepted
//   retired                   wrapping count of completed instructions
//
// Parameters:
//   SETTLE  cycles alu_outmode is held low before alu_bus is sampled (1..7)
//   RET_W   width of the retired counter
module alu_seq #(
    parameter int unsigned SETTLE = 1,
    parameter int unsigned RET_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [7:0]       instr,
    output logic [3:0]       alu_tin,
    output logic [3:0]       alu_pin,
    output logic [1:0]       alu_cmode,
    output logic             alu_inmode,
    output logic             alu_outmode,
    output logic             alu_uacc,
    input  logic [3:0]       alu_bus,
    input  logic [2:0]       alu_flgs,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [3:0]       res_data,
    output logic [2:0]       res_flgs,
    output logic             illegal,
    output logic [RET_W-1:0] retired
);

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_AND = 4'h3;
    localparam logic [3:0] OP_OR  = 4'h4;
    localparam logic [3:0] OP_XOR = 4'h5;
    localparam logic [3:0] OP_OUT = 4'h6;

    // The settle counter is loaded with SETTLE-1 and counts down to zero, so
    // SETTLE_W lasts exactly SETTLE cycles.
    localparam logic [2:0] SETTLE_M1 = 3'(SETTLE - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD,
        SETTLE_W,
        CAPTURE,
        WAIT_RES
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       op_q, op_d;
    logic [3:0]       imm_q, imm_d;
    logic [2:0]       cnt_q, cnt_d;
    logic             res_valid_q, res_valid_d;
    logic [3:0]       res_data_q, res_data_d;
    logic [2:0]       res_flgs_q, res_flgs_d;
    logic             illegal_q, illegal_d;
    logic [RET_W-1:0] retired_q, retired_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            op_q        <= OP_NOP;
            imm_q       <= 4'h0;
            cnt_q       <= 3'd0;
            res_valid_q <= 1'b0;
            res_data_q  <= 4'h0;
            res_flgs_q  <= 3'b000;
            illegal_q   <= 1'b0;
            retired_q   <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            imm_q       <= imm_d;
            cnt_q       <= cnt_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_flgs_q  <= res_flgs_d;
            illegal_q   <= illegal_d;
            retired_q   <= retired_d;
        end
    end

    // Next-state and register updates.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        imm_d       = imm_q;
        cnt_d       = cnt_q;
        // A consumed result drops unless CAPTURE reloads it below (set wins).
        res_valid_d = res_valid_q && !res_ready;
        res_data_d  = res_data_q;
        res_flgs_d  = res_flgs_q;
        illegal_d   = 1'b0;
        retired_d   = retired_q;

        case (state_q)
            IDLE: begin
                if (instr_valid) begin
                    op_d  = instr[7:4];
                    imm_d = instr[3:0];
                    case (instr[7:4])
                        OP_NOP: begin
                            retired_d = retired_q + RET_W'(1);
                        end
                        OP_LDA, OP_ADD, OP_AND, OP_OR, OP_XOR: begin
                            state_d = SETUP;
                        end
                        OP_OUT: begin
                            // Do not overwrite an unconsumed result: park
                            // until the consumer takes it.
                            if (res_valid_q && !res_ready) begin
                                state_d = WAIT_RES;
                            end else begin
                                state_d = SETTLE_W;
                                cnt_d   = SETTLE_M1;
                            end
                        end
                        default: begin
                            illegal_d = 1'b1;
                            retired_d = retired_q + RET_W'(1);
                        end
                    endcase
                end
            end
            SETUP: begin
                state_d = STROBE;
            end
            STROBE: begin
                state_d = HOLD;
            end
            HOLD: begin
                retired_d = retired_q + RET_W'(1);
                state_d   = IDLE;
            end
            WAIT_RES: begin
                if (!res_valid_q || res_ready) begin
                    state_d = SETTLE_W;
                    cnt_d   = SETTLE_M1;
                end
            end
            SETTLE_W: begin
                if (cnt_q == 3'd0) begin
                    state_d = CAPTURE;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            CAPTURE: begin
                res_data_d  = alu_bus;
                res_flgs_d  = alu_flgs;
                res_valid_d = 1'b1;
                retired_d   = retired_q + RET_W'(1);
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ALU control pins are decoded purely from registered state, so they only
    // move on rising clock edges; the strobe is exactly the STROBE state.
    always_comb begin
        alu_tin     = 4'h0;
        alu_pin     = 4'h0;
        alu_cmode   = 2'b00;
        alu_inmode  = 1'b0;
        alu_uacc    = (state_q == STROBE);
        alu_outmode = !((state_q == SETTLE_W) || (state_q == CAPTURE));
        instr_ready = (state_q == IDLE);

        if ((state_q == SETUP) || (state_q == STROBE) || (state_q == HOLD)) begin
            if (op_q == OP_LDA) begin
                alu_pin    = imm_q;
                alu_inmode = 1'b1;
            end else begin
                alu_tin = imm_q;
                case (op_q)
                    OP_AND:  alu_cmode = 2'b01;
                    OP_OR:   alu_cmode = 2'b10;
                    OP_XOR:  alu_cmode = 2'b11;
                    default: alu_cmode = 2'b00;
                endcase
            end
        end
    end

    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_flgs  = res_flgs_q;
    assign illegal   = illegal_q;
    assign retired   = retired_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq -- self-checking bench for alu_seq.
// Contains a small behavioural model of the 4-bit accumulator ALU hooked to the
// sequencer pins. A table of instructions with hand-computed read-outs is
// applied. Hand-written sequences then cover the stall, illegal-opcode,
// reset-in-strobe and counter-wrap cases.
module tb_alu_seq;

    localparam int unsigned SETTLE = 1;
    localparam int unsigned RET_W  = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             instr_valid = 1'b0;
    logic             instr_ready;
    logic [7:0]       instr = 8'h00;
    logic [3:0]       alu_tin, alu_pin;
    logic [1:0]       alu_cmode;
    logic             alu_inmode, alu_outmode, alu_uacc;
    logic [3:0]       alu_bus;
    logic [2:0]       alu_flgs;
    logic             res_valid;
    logic             res_ready = 1'b0;
    logic [3:0]       res_data;
    logic [2:0]       res_flgs;
    logic             illegal;
    logic [RET_W-1:0] retired;

    alu_seq #(.SETTLE(SETTLE), .RET_W(RET_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .alu_tin     (alu_tin),
        .alu_pin     (alu_pin),
        .alu_cmode   (alu_cmode),
        .alu_inmode  (alu_inmode),
        .alu_outmode (alu_outmode),
        .alu_uacc    (alu_uacc),
        .alu_bus     (alu_bus),
        .alu_flgs    (alu_flgs),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_data    (res_data),
        .res_flgs    (res_flgs),
        .illegal     (illegal),
        .retired     (retired)
    );

    always #5 clk = ~clk;

    // ---------------- ALU model ----------------
    logic [3:0] acc;
    logic [2:0] flg;
    logic [3:0] nres;
    logic       ncar;
    logic [4:0] sum;

    always_comb begin
        sum  = {1'b0, acc} + {1'b0, alu_tin};
        nres = 4'h0;
        ncar = 1'b0;
        if (alu_inmode) begin
            nres = alu_pin;
        end else begin
            case (alu_cmode)
                2'b00: begin nres = sum[3:0]; ncar = sum[4]; end
                2'b01: nres = acc & alu_tin;
                2'b10: nres = acc | alu_tin;
                default: nres = acc ^ alu_tin;
            endcase
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            acc <= 4'h0;
            flg <= 3'b000;
        end else if (alu_uacc) begin
            acc <= nres;
            flg <= {ncar, ^nres, (nres == 4'h0)};
        end
    end

    assign alu_bus  = alu_outmode ? 4'h0 : acc;
    assign alu_flgs = flg;

    // ---------------- monitors ----------------
    int   cyc = 0;
    int   uacc_cnt = 0;
    logic uacc_prev = 1'b0;
    logic uacc_dbl = 1'b0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (alu_uacc) uacc_cnt <= uacc_cnt + 1;
        if (alu_uacc && uacc_prev) uacc_dbl <= 1'b1;
        uacc_prev <= alu_uacc;
    end

    // ---------------- checking helpers ----------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    int acc_cyc;

    // Offer one instruction; returns #1 after the accepting edge.
    task automatic send(input logic [7:0] ins);
        @(negedge clk);
        instr_valid = 1'b1;
        instr       = ins;
        for (int k = 0; k < 50 && !instr_ready; k++) @(negedge clk);
        if (!instr_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: instr %0h got ready 0 expected 1", ins);
        end
        @(posedge clk);
        #1;
        acc_cyc     = cyc;
        instr_valid = 1'b0;
        $display("sent instr %02h at cycle %0d", ins, acc_cyc);
    endtask

    // Wait for res_valid (bounded); leaves the bench at a negedge.
    task automatic wait_res(input string name, output int lat);
        lat = -1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (res_valid) begin
                lat = cyc - acc_cyc;
                break;
            end
        end
        if (!res_valid) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: res_valid got 0 expected 1", name);
        end
    endtask

    // Pulse res_ready for one cycle starting at the current negedge.
    task automatic consume();
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    typedef struct {
        logic [7:0] ins;
        bit         has_res;
        logic [3:0] data;
        logic [2:0] flgs;
    } vec_t;

    vec_t vecs[18];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int snap_uacc;
        logic [RET_W-1:0] snap_ret;

        // flags are {carry, parity(odd), zero}
        vecs[0]  = '{8'h15, 1'b0, 4'h0, 3'b000};
        vecs[1]  = '{8'h60, 1'b1, 4'h5, 3'b000};
        vecs[2]  = '{8'h19, 1'b0, 4'h0, 3'b000};
        vecs[3]  = '{8'h28, 1'b0, 4'h0, 3'b000};
        vecs[4]  = '{8'h60, 1'b1, 4'h1, 3'b110};
        vecs[5]  = '{8'h1C, 1'b0, 4'h0, 3'b000};
        vecs[6]  = '{8'h5C, 1'b0, 4'h0, 3'b000};
        vecs[7]  = '{8'h60, 1'b1, 4'h0, 3'b001};
        vecs[8]  = '{8'h1A, 1'b0, 4'h0, 3'b000};
        vecs[9]  = '{8'h35, 1'b0, 4'h0, 3'b000};
        vecs[10] = '{8'h60, 1'b1, 4'h0, 3'b001};
        vecs[11] = '{8'h1A, 1'b0, 4'h0, 3'b000};
        vecs[12] = '{8'h45, 1'b0, 4'h0, 3'b000};
        vecs[13] = '{8'h60, 1'b1, 4'hF, 3'b000};
        vecs[14] = '{8'h21, 1'b0, 4'h0, 3'b000};
        vecs[15] = '{8'h60, 1'b1, 4'h0, 3'b101};
        vecs[16] = '{8'h00, 1'b0, 4'h0, 3'b000};
        vecs[17] = '{8'h60, 1'b1, 4'h0, 3'b101};

        // ---- reset state ----
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_instr_ready", 32'(instr_ready), 32'h1);
        check("rst_outmode",     32'(alu_outmode), 32'h1);
        check("rst_uacc",        32'(alu_uacc),    32'h0);
        check("rst_res_valid",   32'(res_valid),   32'h0);
        check("rst_res_data",    32'(res_data),    32'h0);
        check("rst_res_flgs",    32'(res_flgs),    32'h0);
        check("rst_illegal",     32'(illegal),     32'h0);
        check("rst_retired",     32'(retired),     32'h0);
        check("rst_operands",    32'({alu_tin, alu_pin, alu_cmode, alu_inmode}), 32'h0);

        // ---- table-driven vectors ----
        for (int i = 0; i < 18; i++) begin
            send(vecs[i].ins);
            if (vecs[i].has_res) begin
                wait_res($sformatf("v%0d", i), lat);
                check($sformatf("v%0d_latency", i), 32'(lat), 32'(SETTLE + 1));
                check($sformatf("v%0d_data", i), 32'(res_data), 32'(vecs[i].data));
                check($sformatf("v%0d_flgs", i), 32'(res_flgs), 32'(vecs[i].flgs));
                consume();
            end
        end
        check("table_retired", 32'(retired), 32'd18);
        check("table_uacc_count", 32'(uacc_cnt), 32'd10);

        // ---- strobe window of one LDA ----
        send(8'h13);
        @(negedge clk);   // SETUP
        check("lda_setup_uacc",  32'(alu_uacc), 32'h0);
        check("lda_setup_pins",  32'({alu_pin, alu_inmode, alu_tin, alu_cmode, alu_outmode}), 32'({4'h3, 1'b1, 4'h0, 2'b00, 1'b1}));
        @(negedge clk);   // STROBE
        check("lda_strobe_uacc", 32'(alu_uacc), 32'h1);
        @(negedge clk);   // HOLD
        check("lda_hold_uacc",   32'(alu_uacc), 32'h0);
        check("lda_hold_ready",  32'(instr_ready), 32'h0);
        @(negedge clk);   // IDLE
        check("lda_idle_ready",  32'(instr_ready), 32'h1);

        // ---- ALU op pins ----
        send(8'h47);      // OR 7
        @(negedge clk);
        check("or_setup_pins", 32'({alu_tin, alu_cmode, alu_inmode, alu_pin}), 32'({4'h7, 2'b10, 1'b0, 4'h0}));

        // ---- stall: second OUT with res_ready low ----
        send(8'h60);      // acc = 3|7 = 7
        wait_res("stall1", lat);
        check("stall1_data", 32'(res_data), 32'h7);
        send(8'h1B);      // LDA B while first result still pending
        send(8'h60);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("stall_k%0d", k), 32'({instr_ready, alu_outmode, res_valid, res_data}), 32'({1'b0, 1'b1, 1'b1, 4'h7}));
        end
        consume();
        wait_res("stall2", lat);
        check("stall2_data", 32'(res_data), 32'hB);
        check("stall2_flgs", 32'(res_flgs), 32'(3'b010));
        consume();

        // ---- illegal opcode ----
        snap_uacc = uacc_cnt;
        snap_ret  = retired;
        send(8'h9A);
        @(negedge clk);
        check("illegal_pulse", 32'(illegal), 32'h1);
        check("illegal_retired", 32'(retired), 32'(snap_ret + 1'b1));
        check("illegal_ready", 32'(instr_ready), 32'h1);
        @(negedge clk);
        check("illegal_pulse_end", 32'(illegal), 32'h0);
        check("illegal_no_uacc", 32'(uacc_cnt), 32'(snap_uacc));
        send(8'h60);
        wait_res("illegal_out", lat);
        check("illegal_acc_kept", 32'(res_data), 32'hB);

        // leave this result pending; then reset in the middle of a strobe
        send(8'h1E);
        @(negedge clk);   // SETUP
        @(negedge clk);   // STROBE
        check("pre_rst_uacc", 32'(alu_uacc), 32'h1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_strobe_uacc",    32'(alu_uacc),    32'h0);
        check("rst_strobe_outmode", 32'(alu_outmode), 32'h1);
        check("rst_strobe_valid",   32'(res_valid),   32'h0);
        check("rst_strobe_ready",   32'(instr_ready), 32'h1);
        check("rst_strobe_retired", 32'(retired),     32'h0);
        check("no_double_uacc",     32'(uacc_dbl),    32'h0);

        // ---- back-to-back NOPs wrap the retired counter ----
        instr       = 8'h00;
        instr_valid = 1'b1;
        repeat ((1 << RET_W) - 1) @(posedge clk);
        #1;
        check("nop_retired_max", 32'(retired), 32'((1 << RET_W) - 1));
        check("nop_ready_kept", 32'(instr_ready), 32'h1);
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        check("nop_retired_wrap", 32'(retired), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
